// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : Transfer sequencer for the SPI shift_reg datapath. It handles
//               chip select, SCLK gating, shift enable and RX capture for
//               multi-word frames.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl #(
    parameter int unsigned W        = 8,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] tx_data,
    input  logic         tx_last,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] w_buf_out,
    output logic         transfer_en,
    input  logic [W-1:0] r_buf_in,
    output logic         sclk_en,
    output logic         cs_n,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         overrun,
    output logic         busy
);

    localparam int unsigned c_cnt_max = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int unsigned c_bit_w   = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_NEXT    = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t               state_q,    state_d;
    logic [c_cnt_w-1:0]   cnt_q,      cnt_d;
    logic [c_bit_w-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [W-1:0]         buf_q,      buf_d;
    logic                 last_q,     last_d;
    logic [W-1:0]         rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q,  overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            buf_q      <= '0;
            last_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            buf_q      <= buf_d;
            last_q     <= last_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        buf_d      = buf_q;
        last_d     = last_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        // Consumer handshake; a capture in the same cycle re-sets rx_valid below.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    buf_d   = tx_data;
                    last_d  = tx_last;
                    cnt_d   = c_cnt_w'(CS_SETUP);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q - c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(1)) begin
                    bit_cnt_d = c_bit_w'(W);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bit_cnt_d = bit_cnt_q - c_bit_w'(1);
                if (bit_cnt_q == c_bit_w'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rx_data_d  = r_buf_in;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ready) begin
                    overrun_d = 1'b1;
                end
                if (last_q) begin
                    cnt_d   = c_cnt_w'(CS_HOLD);
                    state_d = S_HOLD;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // Next word of the frame only needs one load cycle; cs_n is already low.
                if (tx_valid) begin
                    buf_d   = tx_data;
                    last_d  = tx_last;
                    cnt_d   = c_cnt_w'(1);
                    state_d = S_SETUP;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_q == S_IDLE) || (state_q == S_NEXT);
    assign cs_n        = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign transfer_en = (state_q == S_SHIFT);
    assign sclk_en     = (state_q == S_SHIFT);
    assign w_buf_out   = buf_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire
